// File: rtl/exec_register_file.sv
`default_nettype none
// ============================================================================
// Module      : exec_register_file
// Description : Execute-stage general-purpose register file with three
//               registered read ports and two write ports. Reads bypass the
//               same-edge writes (wr1 over wr2 over stored value). After reset,
//               a sequential sweep zeroes every entry before regfile_ready
//               rises.
// Ports       : clock, reset (sync, active-high)
//               reg_rd1/2/3 -> reg_rd1/2/3_out   read address / registered data
//               reg_wr1(_data,_enable)          writeback port (wins collisions)
//               reg_wr2(_data,_enable)          base-register update port
//               regfile_ready                   high once the clear sweep is done
//               write_collision                 pulse when both writes hit one address
// Revision    : 1.0 - initial release
// ============================================================================
module exec_register_file #(
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg_rd1,
    input  logic [ADDR_W-1:0] reg_rd2,
    input  logic [ADDR_W-1:0] reg_rd3,
    output logic [DATA_W-1:0] reg_rd1_out,
    output logic [DATA_W-1:0] reg_rd2_out,
    output logic [DATA_W-1:0] reg_rd3_out,
    input  logic [ADDR_W-1:0] reg_wr1,
    input  logic [DATA_W-1:0] reg_wr1_data,
    input  logic              reg_wr1_enable,
    input  logic [ADDR_W-1:0] reg_wr2,
    input  logic [DATA_W-1:0] reg_wr2_data,
    input  logic              reg_wr2_enable,
    output logic              regfile_ready,
    output logic              write_collision
);

    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic              c_ZERO_EN  = (ZERO_REG != 0);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic [DATA_W-1:0] r_rd1_out;
    logic [DATA_W-1:0] r_rd2_out;
    logic [DATA_W-1:0] r_rd3_out;
    logic              r_ready;
    logic              r_coll;

    logic              w_same_addr;
    logic              w_collision;
    logic              w_wr1_en;
    logic              w_wr2_en;
    logic [ADDR_W-1:0] w_rd_addr [3];

    // Collision is judged on the raw strobes so that a clash on the zero
    // register is still reported even though neither write lands.
    assign w_same_addr = (reg_wr1 == reg_wr2);
    assign w_collision = reg_wr1_enable && reg_wr2_enable && w_same_addr;

    // Effective write strobes: port 2 yields to port 1 on the same address,
    // and writes to entry 0 vanish when it is hardwired to zero.
    assign w_wr1_en = reg_wr1_enable && !(c_ZERO_EN && (reg_wr1 == '0));
    assign w_wr2_en = reg_wr2_enable && !(reg_wr1_enable && w_same_addr)
                      && !(c_ZERO_EN && (reg_wr2 == '0));

    assign w_rd_addr[0] = reg_rd1;
    assign w_rd_addr[1] = reg_rd2;
    assign w_rd_addr[2] = reg_rd3;

    // Per-port next read value: the entry as it will be after this edge.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
        logic [DATA_W-1:0] w_next;
        always_comb begin
            w_next = r_mem[w_rd_addr[gi]];
            if (c_ZERO_EN && (w_rd_addr[gi] == '0)) begin
                w_next = '0;
            end else if (w_wr1_en && (reg_wr1 == w_rd_addr[gi])) begin
                w_next = reg_wr1_data;
            end else if (w_wr2_en && (reg_wr2 == w_rd_addr[gi])) begin
                w_next = reg_wr2_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_ST_CLEAR;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_coll    <= 1'b0;
            r_rd1_out <= '0;
            r_rd2_out <= '0;
            r_rd3_out <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            // One entry per cycle; write ports are ignored until the sweep ends.
            r_mem[r_idx] <= '0;
            r_idx        <= r_idx + 1'b1;
            r_coll       <= 1'b0;
            r_rd1_out    <= '0;
            r_rd2_out    <= '0;
            r_rd3_out    <= '0;
            if (r_idx == c_LAST_IDX) begin
                r_state <= c_ST_RUN;
                r_ready <= 1'b1;
            end
        end else begin
            if (w_wr2_en) begin
                r_mem[reg_wr2] <= reg_wr2_data;
            end
            if (w_wr1_en) begin
                r_mem[reg_wr1] <= reg_wr1_data;
            end
            r_coll    <= w_collision;
            r_rd1_out <= g_rd_port[0].w_next;
            r_rd2_out <= g_rd_port[1].w_next;
            r_rd3_out <= g_rd_port[2].w_next;
        end
    end

    assign reg_rd1_out     = r_rd1_out;
    assign reg_rd2_out     = r_rd2_out;
    assign reg_rd3_out     = r_rd3_out;
    assign regfile_ready   = r_ready;
    assign write_collision = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_exec_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_register_file
// Description : Scoreboard bench for exec_register_file. Two instances share
//               the stimulus: one with the zero register enabled, one without.
//               A reference model built from the register-file rules pushes the
//               expected outputs each edge; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_register_file;

    localparam int NR = 64;
    localparam int AW = 6;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rd1, rd2, rd3, wr1, wr2;
    logic [DW-1:0] wr1_data, wr2_data;
    logic          wr1_en, wr2_en;

    logic [DW-1:0] a_o1, a_o2, a_o3, b_o1, b_o2, b_o3;
    logic          a_ready, a_coll, b_ready, b_coll;

    always #5 clock = ~clock;

    exec_register_file #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1)) u_dut_zero (
        .clock(clock), .reset(reset),
        .reg_rd1(rd1), .reg_rd2(rd2), .reg_rd3(rd3),
        .reg_rd1_out(a_o1), .reg_rd2_out(a_o2), .reg_rd3_out(a_o3),
        .reg_wr1(wr1), .reg_wr1_data(wr1_data), .reg_wr1_enable(wr1_en),
        .reg_wr2(wr2), .reg_wr2_data(wr2_data), .reg_wr2_enable(wr2_en),
        .regfile_ready(a_ready), .write_collision(a_coll)
    );

    exec_register_file #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .ZERO_REG(0)) u_dut_nozero (
        .clock(clock), .reset(reset),
        .reg_rd1(rd1), .reg_rd2(rd2), .reg_rd3(rd3),
        .reg_rd1_out(b_o1), .reg_rd2_out(b_o2), .reg_rd3_out(b_o3),
        .reg_wr1(wr1), .reg_wr1_data(wr1_data), .reg_wr1_enable(wr1_en),
        .reg_wr2(wr2), .reg_wr2_data(wr2_data), .reg_wr2_enable(wr2_en),
        .regfile_ready(b_ready), .write_collision(b_coll)
    );

    typedef struct packed {
        logic [DW-1:0] a1, a2, a3, b1, b2, b3;
        logic          ready, coll;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: architectural register contents per instance.
    // ------------------------------------------------------------------
    bit [DW-1:0] m_a [NR];
    bit [DW-1:0] m_b [NR];
    int          m_sweep = 0;
    bit          m_ready = 1'b0;

    initial begin
        forever begin
            exp_t e;
            @(posedge clock);
            e = '0;
            if (reset) begin
                m_sweep = 0;
                m_ready = 1'b0;
            end else if (!m_ready) begin
                m_a[m_sweep] = '0;
                m_b[m_sweep] = '0;
                m_sweep++;
                if (m_sweep == NR) m_ready = 1'b1;
                e.ready = m_ready;
            end else begin
                // Apply port 2 first so port 1 overwrites it on a clash.
                if (wr2_en) begin m_a[wr2] = wr2_data; m_b[wr2] = wr2_data; end
                if (wr1_en) begin m_a[wr1] = wr1_data; m_b[wr1] = wr1_data; end
                m_a[0]  = '0;
                e.a1    = m_a[rd1]; e.a2 = m_a[rd2]; e.a3 = m_a[rd3];
                e.b1    = m_b[rd1]; e.b2 = m_b[rd2]; e.b3 = m_b[rd3];
                e.ready = 1'b1;
                e.coll  = wr1_en && wr2_en && (wr1 == wr2);
            end
            sb.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares every registered output one step after each edge.
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = sb.pop_front();
                check("z_rd1",   a_o1, e.a1);
                check("z_rd2",   a_o2, e.a2);
                check("z_rd3",   a_o3, e.a3);
                check("z_ready", DW'(a_ready), DW'(e.ready));
                check("z_coll",  DW'(a_coll),  DW'(e.coll));
                check("n_rd1",   b_o1, e.b1);
                check("n_rd2",   b_o2, e.b2);
                check("n_rd3",   b_o3, e.b3);
                check("n_ready", DW'(b_ready), DW'(e.ready));
                check("n_coll",  DW'(b_coll),  DW'(e.coll));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change on the falling edge only.
    // ------------------------------------------------------------------
    task automatic drive(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                         input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic e2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        rd1 = r1; rd2 = r2; rd3 = r3;
        wr1_en = e1; wr1 = a1; wr1_data = d1;
        wr2_en = e2; wr2 = a2; wr2_data = d2;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        rd1 = '0; rd2 = '0; rd3 = '0;
        wr1 = '0; wr2 = '0; wr1_data = '0; wr2_data = '0;
        wr1_en = 1'b0; wr2_en = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Sweep: a write issued now must be lost.
        drive(6'd5, 6'd63, 6'd1, 1'b1, 6'd7, 16'hAAAA, 1'b0, 6'd0, 16'h0);
        idle(66);
        drive(6'd5, 6'd63, 6'd1, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
        drive(6'd7, 6'd7, 6'd7, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);

        // Basic write then read on both ports.
        drive(6'd0, 6'd0, 6'd0, 1'b1, 6'd10, 16'h1234, 1'b1, 6'd11, 16'hBEEF);
        drive(6'd10, 6'd11, 6'd11, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);

        // Same-edge bypass from each write port.
        drive(6'd12, 6'd13, 6'd12, 1'b1, 6'd12, 16'h00FF, 1'b1, 6'd13, 16'h7E7E);

        // Collision: port 1 wins, then re-read.
        drive(6'd20, 6'd20, 6'd20, 1'b1, 6'd20, 16'h1111, 1'b1, 6'd20, 16'h2222);
        drive(6'd20, 6'd0, 6'd0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);

        // Zero register, including a collision on entry 0.
        drive(6'd0, 6'd0, 6'd0, 1'b1, 6'd0, 16'hFFFF, 1'b0, 6'd0, 16'h0);
        drive(6'd0, 6'd0, 6'd0, 1'b1, 6'd0, 16'hABCD, 1'b1, 6'd0, 16'h4321);
        drive(6'd0, 6'd20, 6'd10, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);

        // Randomized traffic with biased address reuse.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a1, a2;
            a1 = AW'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 15));
            drive(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 63)),
                  1'($urandom), a1, DW'($urandom),
                  1'($urandom), a2, DW'($urandom));
        end

        // Reset during operation and again mid-sweep at index 30.
        drive(6'd3, 6'd0, 6'd0, 1'b1, 6'd3, 16'h5555, 1'b0, 6'd0, 16'h0);
        drive(6'd3, 6'd3, 6'd3, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(30);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 66; i++) drive(6'd3, 6'd0, 6'd63, 1'b1, 6'd3, 16'h9999, 1'b0, 6'd0, 16'h0);
        drive(6'd3, 6'd3, 6'd3, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
